imem_boot_loader: RTL and testbench

//  Loads a program image into the instruction memory of RISCV_Pipeline over a byte stream.

---
 rtl/riscv_defs.sv | 17 +
 rtl/byte_word_packer.sv | 31 +++
 rtl/imem_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared loader definitions: state encoding, header size, instruction width
package riscv_defs;

   localparam int HDR_BYTES = 2;
   localparam int INSTR_W   = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR0  = 3'd1,
      HDR1  = 3'd2,
      DATA  = 3'd3,
      CSUM  = 3'd4,
      DONE  = 3'd5,
      ERROR = 3'd6
   } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - assembles little-endian bytes into instruction words
module byte_word_packer
   import riscv_defs::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               word_valid,
   output logic [INSTR_W-1:0] word
);

   logic [1:0]         idx;
   logic [INSTR_W-9:0] hold;

   // Bytes shift in from the top so the first byte ends up in the low lane.
   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         idx  <= 2'd0;
         hold <= '0;
      end else if (byte_valid) begin
         idx  <= idx + 2'd1;
         hold <= {byte_data, hold[INSTR_W-9:8]};
      end
   end

   assign word_valid = byte_valid && (idx == 2'd3);
   assign word       = {byte_data, hold};

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program image into instruction memory while holding the core
// Optional trailing checksum byte enabled by IMEM_CHECKSUM_EN.
module imem_boot_loader
   import riscv_defs::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               core_hold,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [ADDR_W:0]    words_loaded
);

   localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

   state_t state, state_n;

   logic [8*(HDR_BYTES-1)-1:0] hdr_lo;
   logic [15:0]                hdr_n;
   logic [15:0]                n_words;
   logic                       take;
   logic                       start_go;
   logic                       word_valid;
   logic [INSTR_W-1:0]         word;
   logic                       last_word;

   assign rx_ready  = state inside {HDR0, HDR1, DATA, CSUM};
   assign busy      = rx_ready;
   assign take      = rx_valid && rx_ready;
   assign start_go  = start && (state inside {IDLE, DONE, ERROR});
   assign hdr_n     = {rx_data, hdr_lo};
   assign last_word = word_valid && ((17'(words_loaded) + 17'd1) == {1'b0, n_words});

`ifdef IMEM_CHECKSUM_EN
   logic [7:0] csum;
   logic       csum_ok;

   assign csum_ok = (csum + rx_data) == 8'h00;

   always_ff @(posedge clock) begin
      if (!reset) begin
         csum <= 8'h00;
      end else if (start_go) begin
         csum <= 8'h00;
      end else if (take) begin
         csum <= csum + rx_data;
      end
   end
`endif

   byte_word_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (start_go),
      .byte_valid (take && (state == DATA)),
      .byte_data  (rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) state_n = HDR0;
         end
         HDR0: begin
            if (take) state_n = HDR1;
         end
         HDR1: begin
            if (take) begin
               if (hdr_n == 16'd0) begin
`ifdef IMEM_CHECKSUM_EN
                  state_n = CSUM;
`else
                  state_n = DONE;
`endif
               end else if ({1'b0, hdr_n} > CAP) begin
                  state_n = ERROR;
               end else begin
                  state_n = DATA;
               end
            end
         end
         DATA: begin
            if (last_word) begin
`ifdef IMEM_CHECKSUM_EN
               state_n = CSUM;
`else
               state_n = DONE;
`endif
            end
         end
`ifdef IMEM_CHECKSUM_EN
         CSUM: begin
            if (take) state_n = csum_ok ? DONE : ERROR;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hdr_lo       <= '0;
         n_words      <= 16'd0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         core_hold    <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         imem_we <= 1'b0;
         if (state == HDR0 && take) hdr_lo <= rx_data;
         if (state == HDR1 && take) n_words <= hdr_n;
         if (word_valid) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= word;
            words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
         end
         // Release lands one cycle after DONE so the final write is already out.
         if (state == DONE) core_hold <= 1'b0;
         if (start_go) begin
            core_hold    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
         end
         if (state_n == DONE && state != DONE) begin
            done <= 1'b1;
            err  <= 1'b0;
         end
         if (state_n == ERROR && state != ERROR) begin
            err  <= 1'b1;
            done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_hold;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int hold_fall = -1;
   logic prev_hold = 1'b0;

   logic [ADDR_W-1:0] wa[$];
   logic [31:0]       wd[$];
   int                wc[$];
   logic [7:0]        stim[$];
   logic [31:0]       img[3];

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_hold    (core_hold),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
         wc.push_back(cyc);
      end
      if (prev_hold && !core_hold) hold_fall = cyc;
      prev_hold = core_hold;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      hold_fall = -1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Sends stim[first..last]; with toggle set, rx_valid drops for one cycle after each byte.
   task automatic send(input int first, input int last, input bit toggle);
      for (int i = first; i <= last; i++) begin
         int wait_cnt;
         rx_data  = stim[i];
         rx_valid = 1'b1;
         wait_cnt = 0;
         while (!rx_ready && wait_cnt < 20) begin
            tick(1);
            wait_cnt++;
         end
         if (!rx_ready) begin
            check("rx_ready_timeout", 64'(rx_ready), 64'd1);
            rx_valid = 1'b0;
            return;
         end
         tick(1);
         if (toggle) begin
            rx_valid = 1'b0;
            tick(1);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
      check({tag, "_we"}, 64'(imem_we), 64'd0);
      check({tag, "_addr"}, 64'(imem_addr), 64'd0);
      check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
      check({tag, "_hold"}, 64'(core_hold), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_words"}, 64'(words_loaded), 64'd0);
   endtask

   task automatic check_image(input string tag, input int gap);
      check({tag, "_nwrites"}, 64'(wa.size()), 64'd3);
      if (wa.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wa[i]), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(wd[i]), 64'(img[i]));
         end
         check({tag, "_gap01"}, 64'(wc[1] - wc[0]), 64'(gap));
         check({tag, "_gap12"}, 64'(wc[2] - wc[1]), 64'(gap));
      end
      check({tag, "_words"}, 64'(words_loaded), 64'd3);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_hold"}, 64'(core_hold), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic load_image();
      stim = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00};
`ifdef IMEM_CHECKSUM_EN
      stim.push_back(8'h43);
`endif
   endtask

   initial begin
      img[0] = 32'h00100013;
      img[1] = 32'h00500093;
      img[2] = 32'h00A00113;
      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick(2);
      check_idle("reset");
      reset = 1'b1;

      rx_valid = 1'b1;
      rx_data  = 8'h55;
      tick(1);
      check("idle_rx_ready", 64'(rx_ready), 64'd0);
      tick(2);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_nwrites", 64'(wa.size()), 64'd0);
      rx_valid = 1'b0;

      // Back-to-back image.
      clear_log();
      load_image();
      pulse_start();
      check("t1_hold_rise", 64'(core_hold), 64'd1);
      check("t1_busy", 64'(busy), 64'd1);
      send(0, stim.size() - 1, 1'b0);
      tick(3);
      check_image("t1", 4);
      if (wc.size() == 3) begin
`ifdef IMEM_CHECKSUM_EN
         check("t1_hold_fall", 64'(hold_fall - wc[2]), 64'd2);
`else
         check("t1_hold_fall", 64'(hold_fall - wc[2]), 64'd1);
`endif
      end

      // Same image with stalls, started from DONE.
      clear_log();
      pulse_start();
      check("t2_words_clr", 64'(words_loaded), 64'd0);
      check("t2_done_clr", 64'(done), 64'd0);
      send(0, stim.size() - 1, 1'b1);
      tick(3);
      check_image("t2", 8);

      // Empty image.
      clear_log();
      stim = '{8'h00, 8'h00};
`ifdef IMEM_CHECKSUM_EN
      stim.push_back(8'h00);
`endif
      pulse_start();
      send(0, stim.size() - 1, 1'b0);
      tick(3);
      check("t3_zero_done", 64'(done), 64'd1);
      check("t3_zero_err", 64'(err), 64'd0);
      check("t3_zero_nwrites", 64'(wa.size()), 64'd0);
      check("t3_zero_words", 64'(words_loaded), 64'd0);
      check("t3_zero_hold", 64'(core_hold), 64'd0);

      // Oversized image: N = 2**ADDR_W + 1.
      stim = '{8'h01, 8'h01};
      pulse_start();
      send(0, 1, 1'b0);
      tick(3);
      check("t3_big_err", 64'(err), 64'd1);
      check("t3_big_done", 64'(done), 64'd0);
      check("t3_big_hold", 64'(core_hold), 64'd1);
      check("t3_big_rx_ready", 64'(rx_ready), 64'd0);
      check("t3_big_nwrites", 64'(wa.size()), 64'd0);

      // Reset after six payload bytes of a two-word image.
      stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      pulse_start();
      send(0, 7, 1'b0);
      check("t4_pre_words", 64'(words_loaded), 64'd1);
      clear_log();
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      check_idle("t4_reset");
      tick(3);
      check("t4_no_write", 64'(wa.size()), 64'd0);

      stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_CHECKSUM_EN
      stim.push_back(8'hEC);
`endif
      pulse_start();
      send(0, stim.size() - 1, 1'b0);
      tick(3);
      check("t4_nwrites", 64'(wa.size()), 64'd1);
      if (wa.size() == 1) begin
         check("t4_addr", 64'(wa[0]), 64'd0);
         check("t4_data", 64'(wd[0]), 64'h00000013);
      end
      check("t4_done", 64'(done), 64'd1);
      check("t4_words", 64'(words_loaded), 64'd1);

`ifdef IMEM_CHECKSUM_EN
      // Bad checksum: word is still written.
      clear_log();
      stim[6] = 8'hEE;
      pulse_start();
      send(0, 6, 1'b0);
      tick(3);
      check("t5_err", 64'(err), 64'd1);
      check("t5_done", 64'(done), 64'd0);
      check("t5_hold", 64'(core_hold), 64'd1);
      check("t5_nwrites", 64'(wa.size()), 64'd1);
      if (wa.size() == 1) begin
         check("t5_addr", 64'(wa[0]), 64'd0);
         check("t5_data", 64'(wd[0]), 64'h00000013);
      end
`endif

      // Start pulsed mid-DATA is ignored.
      clear_log();
      load_image();
      pulse_start();
      send(0, 7, 1'b0);
      pulse_start();
      check("t6_busy", 64'(busy), 64'd1);
      check("t6_words_kept", 64'(words_loaded), 64'd1);
      send(8, stim.size() - 1, 1'b0);
      tick(3);
      check("t6_nwrites", 64'(wa.size()), 64'd3);
      if (wa.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_addr%0d", i), 64'(wa[i]), 64'(i));
            check($sformatf("t6_data%0d", i), 64'(wd[i]), 64'(img[i]));
         end
      end
      check("t6_done", 64'(done), 64'd1);
      check("t6_words", 64'(words_loaded), 64'd3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
